// File: rtl/calc_sequencer_pkg.sv
// Shared types and ASCII constants for the two-digit calculator sequencer.
// The state enumeration is shared so other blocks can decode it if needed.
package calc_sequencer_pkg;

  typedef enum logic [3:0] {
    GET_D0,
    GET_D1,
    GET_OP,
    GET_D2,
    GET_D3,
    GET_EQ,
    START,
    WAIT,
    SEND_HI,
    SEND_LO,
    SEND_ERR
  } state_t;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_E     = 8'h45;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_0) && (c <= ASCII_9);
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// Character stream, result stream, adder and status signals of the sequencer.
// slave is the sequencer side; master is the surrounding parent/front end.
interface calc_sequencer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       add_start;
  logic       add_subtract;
  logic [7:0] add_r11;
  logic [7:0] add_r12;
  logic [7:0] add_r21;
  logic [7:0] add_r22;
  logic [7:0] add_data1;
  logic [7:0] add_data2;
  logic       add_rdy1;
  logic       add_rdy2;
  logic       busy;
  logic       drop;

  modport slave (
    input  rx_data, rx_valid, tx_ready, add_data1, add_data2, add_rdy1, add_rdy2,
    output tx_data, tx_valid, add_start, add_subtract,
           add_r11, add_r12, add_r21, add_r22, busy, drop
  );

  modport master (
    output rx_data, rx_valid, tx_ready, add_data1, add_data2, add_rdy1, add_rdy2,
    input  tx_data, tx_valid, add_start, add_subtract,
           add_r11, add_r12, add_r21, add_r22, busy, drop
  );
endinterface

// File: rtl/calc_sequencer.sv
// Parses "DD?DD=" from the serial front end, runs the external ASCII adder,
// and streams the two result digits (or '?' / 'E' on error) back out.
//
// state    | meaning
// GET_D0   | idle, waiting for tens digit of A
// GET_D1   | waiting for ones digit of A
// GET_OP   | waiting for '+' or '-'
// GET_D2   | waiting for tens digit of B
// GET_D3   | waiting for ones digit of B
// GET_EQ   | waiting for '='
// START    | one-cycle adder start, timeout counter loaded
// WAIT     | waiting for adder completion or timeout
// SEND_HI  | presenting result tens digit
// SEND_LO  | presenting result ones digit
// SEND_ERR | presenting '?' (bad input) or 'E' (adder timeout)
module calc_sequencer
  import calc_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 32
) (
  input logic             clk,
  input logic             rst,
  calc_sequencer_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_r11, r_r12, r_r21, r_r22;
  logic [7:0]    w_r11_nxt, w_r12_nxt, w_r21_nxt, w_r22_nxt;
  logic          r_sub, w_sub_nxt;
  logic [7:0]    r_res_hi, r_res_lo, w_res_hi_nxt, w_res_lo_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]    r_tx_data, w_tx_data_nxt;
  logic          r_tx_valid, w_tx_valid_nxt;
  logic          w_hs;

  assign w_hs = r_tx_valid && bus.tx_ready;

  always_comb begin
    w_state_nxt   = r_state;
    w_r11_nxt     = r_r11;
    w_r12_nxt     = r_r12;
    w_r21_nxt     = r_r21;
    w_r22_nxt     = r_r22;
    w_sub_nxt     = r_sub;
    w_res_hi_nxt  = r_res_hi;
    w_res_lo_nxt  = r_res_lo;
    w_cnt_nxt     = r_cnt;
    w_tx_data_nxt = r_tx_data;

    case (r_state)
      GET_D0: if (bus.rx_valid) begin
        if (is_digit(bus.rx_data)) begin
          w_r11_nxt   = bus.rx_data;
          w_state_nxt = GET_D1;
        end else begin
          w_state_nxt   = SEND_ERR;
          w_tx_data_nxt = ASCII_QMARK;
        end
      end
      GET_D1: if (bus.rx_valid) begin
        if (is_digit(bus.rx_data)) begin
          w_r12_nxt   = bus.rx_data;
          w_state_nxt = GET_OP;
        end else begin
          w_state_nxt   = SEND_ERR;
          w_tx_data_nxt = ASCII_QMARK;
        end
      end
      GET_OP: if (bus.rx_valid) begin
        if (bus.rx_data == ASCII_PLUS || bus.rx_data == ASCII_MINUS) begin
          w_sub_nxt   = (bus.rx_data == ASCII_MINUS);
          w_state_nxt = GET_D2;
        end else begin
          w_state_nxt   = SEND_ERR;
          w_tx_data_nxt = ASCII_QMARK;
        end
      end
      GET_D2: if (bus.rx_valid) begin
        if (is_digit(bus.rx_data)) begin
          w_r21_nxt   = bus.rx_data;
          w_state_nxt = GET_D3;
        end else begin
          w_state_nxt   = SEND_ERR;
          w_tx_data_nxt = ASCII_QMARK;
        end
      end
      GET_D3: if (bus.rx_valid) begin
        if (is_digit(bus.rx_data)) begin
          w_r22_nxt   = bus.rx_data;
          w_state_nxt = GET_EQ;
        end else begin
          w_state_nxt   = SEND_ERR;
          w_tx_data_nxt = ASCII_QMARK;
        end
      end
      GET_EQ: if (bus.rx_valid) begin
        if (bus.rx_data == ASCII_EQ) begin
          w_state_nxt = START;
        end else begin
          w_state_nxt   = SEND_ERR;
          w_tx_data_nxt = ASCII_QMARK;
        end
      end
      START: begin
        w_cnt_nxt   = CW'(TIMEOUT);
        w_state_nxt = WAIT;
      end
      WAIT: begin
        w_cnt_nxt = (r_cnt != '0) ? r_cnt - CW'(1) : r_cnt;
        if (bus.add_rdy1) w_res_hi_nxt = bus.add_data1;
        // Completion wins over expiry when both land in the same cycle.
        if (bus.add_rdy2) begin
          w_res_lo_nxt  = bus.add_data2;
          w_state_nxt   = SEND_HI;
          w_tx_data_nxt = w_res_hi_nxt;
        end else if (r_cnt <= CW'(1)) begin
          w_state_nxt   = SEND_ERR;
          w_tx_data_nxt = ASCII_E;
        end
      end
      SEND_HI: if (w_hs) begin
        w_state_nxt   = SEND_LO;
        w_tx_data_nxt = r_res_lo;
      end
      SEND_LO:  if (w_hs) w_state_nxt = GET_D0;
      SEND_ERR: if (w_hs) w_state_nxt = GET_D0;
      default:  w_state_nxt = GET_D0;
    endcase

    w_tx_valid_nxt = (w_state_nxt == SEND_HI) || (w_state_nxt == SEND_LO) ||
                     (w_state_nxt == SEND_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= GET_D0;
      r_r11      <= ASCII_0;
      r_r12      <= ASCII_0;
      r_r21      <= ASCII_0;
      r_r22      <= ASCII_0;
      r_sub      <= 1'b0;
      r_res_hi   <= ASCII_0;
      r_res_lo   <= ASCII_0;
      r_cnt      <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_r11      <= w_r11_nxt;
      r_r12      <= w_r12_nxt;
      r_r21      <= w_r21_nxt;
      r_r22      <= w_r22_nxt;
      r_sub      <= w_sub_nxt;
      r_res_hi   <= w_res_hi_nxt;
      r_res_lo   <= w_res_lo_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
    end
  end

  assign bus.tx_data      = r_tx_data;
  assign bus.tx_valid     = r_tx_valid;
  assign bus.add_start    = (r_state == START);
  assign bus.add_subtract = r_sub;
  assign bus.add_r11      = r_r11;
  assign bus.add_r12      = r_r12;
  assign bus.add_r21      = r_r21;
  assign bus.add_r22      = r_r22;
  assign bus.busy         = (r_state != GET_D0);
  assign bus.drop         = bus.rx_valid &&
                            (r_state inside {START, WAIT, SEND_HI, SEND_LO, SEND_ERR});

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: expression-level model of the expected
// output characters, a behavioural ASCII adder, and a per-cycle output checker.
module tb_calc_sequencer;
  import calc_sequencer_pkg::*;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  calc_sequencer_if bus();

  calc_sequencer #(.TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_ops[4];
  logic       exp_sub = 1'b0;
  int         n_starts = 0;
  logic [7:0] last_tx[2];
  int         adder_lat  = 2;
  bit         adder_coin = 1'b0;
  bit         adder_en   = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle output checker: accepted characters against the expected stream,
  // stall stability, and operands at every adder start.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("tx_hold_valid", bus.tx_valid, 1);
        check("tx_hold_data", bus.tx_data, prev_data);
      end
      if (bus.add_start) begin
        n_starts++;
        check("op_r11", bus.add_r11, exp_ops[0]);
        check("op_r12", bus.add_r12, exp_ops[1]);
        check("op_r21", bus.add_r21, exp_ops[2]);
        check("op_r22", bus.add_r22, exp_ops[3]);
        check("op_sub", bus.add_subtract, exp_sub);
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_unexpected: got %0h, expected no transfer", bus.tx_data);
        end else begin
          check("tx_data", bus.tx_data, exp_q.pop_front());
        end
        last_tx[0] = last_tx[1];
        last_tx[1] = bus.tx_data;
      end
      prev_stall = bus.tx_valid && !bus.tx_ready;
      prev_data  = bus.tx_data;
    end
  end

  // Behavioural ASCII adder: computes the result from the operands it is given.
  initial begin
    int a, b, v;
    logic [7:0] hi, lo;
    bus.add_rdy1  = 1'b0;
    bus.add_rdy2  = 1'b0;
    bus.add_data1 = 8'h30;
    bus.add_data2 = 8'h30;
    forever begin
      @(negedge clk);
      if (bus.add_start && !rst && adder_en) begin
        a  = (bus.add_r11 - 48) * 10 + (bus.add_r12 - 48);
        b  = (bus.add_r21 - 48) * 10 + (bus.add_r22 - 48);
        v  = bus.add_subtract ? a - b : a + b;
        hi = 8'(48 + v / 10);
        lo = 8'(48 + v % 10);
        if (adder_coin) begin
          repeat (adder_lat) @(posedge clk);
          #1;
          bus.add_data1 = hi; bus.add_data2 = lo;
          bus.add_rdy1 = 1'b1; bus.add_rdy2 = 1'b1;
          @(posedge clk); #1;
          bus.add_rdy1 = 1'b0; bus.add_rdy2 = 1'b0;
        end else begin
          repeat (adder_lat - 1) @(posedge clk);
          #1;
          bus.add_data1 = hi; bus.add_rdy1 = 1'b1;
          @(posedge clk); #1;
          bus.add_rdy1 = 1'b0;
          bus.add_data2 = lo; bus.add_rdy2 = 1'b1;
          @(posedge clk); #1;
          bus.add_rdy2 = 1'b0;
        end
      end
    end
  end

  task automatic send_char(input logic [7:0] c, input logic exp_drop);
    bus.rx_data  = c;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    check("drop", bus.drop, exp_drop);
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.tx_valid && !bus.busy) begin
        tick();
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_idle: still busy or %0d chars pending after %0d cycles, expected idle",
             exp_q.size(), budget);
    tick();
  endtask

  task automatic check_reset_vals();
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_add_start", bus.add_start, 0);
    check("rst_add_sub", bus.add_subtract, 0);
    check("rst_r11", bus.add_r11, 8'h30);
    check("rst_r12", bus.add_r12, 8'h30);
    check("rst_r21", bus.add_r21, 8'h30);
    check("rst_r22", bus.add_r22, 8'h30);
    check("rst_busy", bus.busy, 0);
    check("rst_drop", bus.drop, 0);
  endtask

  // Feeds "a1a0 op b1b0 =", expects the arithmetic result digits back.
  task automatic run_expr(input logic [7:0] a1, a0, op, b1, b0,
                          input int lat, input bit coin, input int hold, input bit poke);
    int a, b, v, k, kstart, s0;
    a = (a1 - 48) * 10 + (a0 - 48);
    b = (b1 - 48) * 10 + (b0 - 48);
    v = (op == 8'h2D) ? a - b : a + b;
    exp_q.push_back(8'(48 + v / 10));
    exp_q.push_back(8'(48 + v % 10));
    exp_ops    = '{a1, a0, b1, b0};
    exp_sub    = (op == 8'h2D);
    adder_lat  = lat;
    adder_coin = coin;
    adder_en   = 1'b1;
    bus.tx_ready = (hold == 0);
    s0 = n_starts;
    send_char(a1, 0);
    send_char(a0, 0);
    send_char(op, 0);
    send_char(b1, 0);
    send_char(b0, 0);
    send_char(8'h3D, 0);
    kstart = 1;
    if (poke) begin
      tick();
      tick();
      send_char(8'h37, 1);
      @(negedge clk);
      check("drop_one_cycle", bus.drop, 0);
      check("busy_in_wait", bus.busy, 1);
      kstart = 5;
    end
    for (k = kstart; k <= 200; k++) begin
      @(negedge clk);
      if (bus.tx_valid) break;
    end
    check("latency_eq_to_tx", k, lat + 2);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      @(posedge clk);
      #1 bus.tx_ready = 1'b1;
    end
    wait_idle(100);
    check("add_start_count", n_starts - s0, 1);
    check("busy_after", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int s0, j;
    last_tx[0] = 8'h00;
    last_tx[1] = 8'h00;
    exp_ops    = '{8'h30, 8'h30, 8'h30, 8'h30};
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_reset_vals();
    tick();
    rst = 1'b0;

    run_expr("1", "2", "+", "3", "4", 3, 0, 0, 0);
    check("add_hi_lit", last_tx[0], 8'h34);
    check("add_lo_lit", last_tx[1], 8'h36);

    run_expr("5", "7", "-", "2", "3", 2, 0, 0, 0);
    check("sub_hi_lit", last_tx[0], 8'h33);
    check("sub_lo_lit", last_tx[1], 8'h34);

    // Illegal character.
    s0 = n_starts;
    exp_q.push_back(8'h3F);
    send_char("1", 0);
    send_char("x", 0);
    wait_idle(50);
    check("err_char_lit", last_tx[1], 8'h3F);
    check("err_no_start", n_starts - s0, 0);

    run_expr("0", "0", "+", "0", "0", 1, 1, 0, 0);
    check("zero_hi_lit", last_tx[0], 8'h30);
    check("zero_lo_lit", last_tx[1], 8'h30);

    // Adder never completes: 'E' is registered TO edges after the edge that
    // samples add_start, i.e. first seen TO+1 cycles after the add_start cycle.
    adder_en = 1'b0;
    exp_ops  = '{8'h33, 8'h34, 8'h31, 8'h32};
    exp_sub  = 1'b0;
    exp_q.push_back(8'h45);
    s0 = n_starts;
    send_char("3", 0);
    send_char("4", 0);
    send_char("+", 0);
    send_char("1", 0);
    send_char("2", 0);
    send_char("=", 0);
    for (j = 0; j < 10; j++) begin
      @(negedge clk);
      if (bus.add_start) break;
    end
    check("timeout_saw_start", bus.add_start, 1);
    for (j = 1; j <= 100; j++) begin
      @(negedge clk);
      if (bus.tx_valid) break;
    end
    check("timeout_cycles", j, TO + 1);
    check("timeout_char_lit", bus.tx_data, 8'h45);
    wait_idle(50);
    check("timeout_start_count", n_starts - s0, 1);
    check("timeout_back_idle", bus.busy, 0);

    // Completion on the last cycle of the window beats expiry.
    run_expr("9", "9", "-", "0", "9", TO, 0, 0, 0);
    check("edge_hi_lit", last_tx[0], 8'h39);
    check("edge_lo_lit", last_tx[1], 8'h30);

    run_expr("4", "5", "+", "4", "4", 2, 0, 10, 0);
    check("bp_hi_lit", last_tx[0], 8'h38);
    check("bp_lo_lit", last_tx[1], 8'h39);

    run_expr("2", "0", "+", "1", "5", 6, 0, 0, 1);
    check("drop_hi_lit", last_tx[0], 8'h33);
    check("drop_lo_lit", last_tx[1], 8'h35);

    // Reset in the middle of WAIT.
    adder_lat  = 20;
    adder_coin = 1'b0;
    adder_en   = 1'b1;
    exp_ops    = '{8'h31, 8'h31, 8'h31, 8'h31};
    exp_sub    = 1'b0;
    send_char("1", 0);
    send_char("1", 0);
    send_char("+", 0);
    send_char("1", 0);
    send_char("1", 0);
    send_char("=", 0);
    tick();
    tick();
    tick();
    s0 = n_starts;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("abort_no_tx_valid", bus.tx_valid, 0);
    end
    check("abort_no_start", n_starts - s0, 0);
    tick();

    run_expr("9", "8", "-", "4", "5", 4, 0, 0, 0);
    check("post_rst_hi_lit", last_tx[0], 8'h35);
    check("post_rst_lo_lit", last_tx[1], 8'h33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
